// File: rtl/sub_shift_rows.sv
// AES SubBytes+ShiftRows over four shared S-boxes, one input column per cycle.
// Latency: 4 cycles from accept to out_valid; throughput one state per 5 cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready follows out_ready there.
module sub_shift_rows (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // FIPS-197 forward S-box, entry 0x00 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t       state_q, state_d;
  logic [1:0]   col_q;
  logic [127:0] st_q;
  logic [127:0] out_q;
  logic [127:0] out_d;
  logic         accept;

  // Entry x sits at bits 2047-8x; that top bit index is {~x, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  assign accept = in_valid && in_ready;
  assign out    = out_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: a DONE with a waiting input hands straight off to BUSY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (col_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: in_ready is combinational on out_ready only while DONE
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      BUSY:    in_ready = 1'b0;
      DONE:    begin in_ready = out_ready; out_valid = 1'b1; end
      default: in_ready = 1'b0;
    endcase
  end

  // Capture the input state on accept and step the column counter while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '0;
      col_q <= 2'd0;
    end else if (accept) begin
      st_q  <= in;
      col_q <= 2'd0;
    end else if (state_q == BUSY) begin
      col_q <= col_q + 2'd1;
    end
  end

  // Byte (row r, column c) lives at top bit {~c, ~r, 3'b111}; it lands in column c-r
  always_comb begin
    out_d = out_q;
    for (int r = 0; r < 4; r++) begin
      out_d[{~(col_q - 2'(r)), ~2'(r), 3'b111} -: 8] =
        sbox(st_q[{~col_q, ~2'(r), 3'b111} -: 8]);
    end
  end

  // Output register only moves while a column is being processed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    out_q <= '0;
    else if (state_q == BUSY)   out_q <= out_d;
  end

endmodule

// File: tb/tb_sub_shift_rows.sv
// Scoreboard bench for sub_shift_rows: directed vectors, queue of expected results.
// Monitor pops and compares on every out_valid && out_ready transfer.
// Also covers latency, back-pressure hold, back-to-back cadence and mid-busy reset.
module tb_sub_shift_rows;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];
  int xfer_t[$];
  bit b2b_on = 0;

  localparam logic [127:0] V_FIPS  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E_FIPS  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V_ZERO  = 128'h0;
  localparam logic [127:0] E_ZERO  = {16{8'h63}};
  localparam logic [127:0] V_ROW   = 128'h00010203_10111213_20212223_30313233;
  localparam logic [127:0] E_ROW   = 128'h638293c3_cafd237b_b7c7777d_047cc926;
  localparam logic [127:0] V_53    = {16{8'h53}};
  localparam logic [127:0] E_53    = {16{8'hed}};
  localparam logic [127:0] V_FF    = {16{8'hff}};
  localparam logic [127:0] E_FF    = {16{8'h16}};

  sub_shift_rows dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h with no expected result queued", out);
      end else begin
        check("out_data", out, exp_q.pop_front());
      end
      if (b2b_on) xfer_t.push_back(cyc);
    end
  end

  // Offer v until accepted; optionally queue its expected result
  task automatic issue(input logic [127:0] v, input logic [127:0] e, input bit want,
                       input bit keep, input bit handoff);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in       = v;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 128'(n < 50), 128'd1);
    if (want) exp_q.push_back(e);
    if (handoff) check("handoff_with_transfer", 128'(out_valid), 128'd1);
    @(posedge clk); #1;
    in_valid = keep;
    if (!keep) in = ~v;
  endtask

  // Negedges after the accept edge until out_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in        = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out", out, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'd1);
    check("idle_out_valid", 128'(out_valid), 128'd0);

    // Single states with latency check
    out_ready = 1'b1;
    issue(V_FIPS, E_FIPS, 1'b1, 1'b0, 1'b0);
    wait_valid(n);
    check("latency_fips", 128'(n), 128'd4);
    issue(V_ZERO, E_ZERO, 1'b1, 1'b0, 1'b0);
    wait_valid(n);
    check("latency_zero", 128'(n), 128'd4);
    issue(V_ROW, E_ROW, 1'b1, 1'b0, 1'b0);
    wait_valid(n);
    check("latency_row", 128'(n), 128'd4);
    @(posedge clk); #1;

    // Back-pressure: hold DONE for 10 cycles with a new input offered
    out_ready = 1'b0;
    issue(V_53, E_53, 1'b1, 1'b0, 1'b0);
    wait_valid(n);
    check("latency_bp", 128'(n), 128'd4);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in       = V_FF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out_stable", out, E_53);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_after_out_valid", 128'(out_valid), 128'd0);
    check("bp_after_in_ready", 128'(in_ready), 128'd1);

    // Back-to-back with in_valid and out_ready high
    out_ready = 1'b1;
    xfer_t.delete();
    b2b_on = 1'b1;
    issue(V_FIPS, E_FIPS, 1'b1, 1'b1, 1'b0);
    issue(V_ROW, E_ROW, 1'b1, 1'b1, 1'b1);
    issue(V_FF, E_FF, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    b2b_on = 1'b0;
    check("b2b_drained", 128'(exp_q.size()), 128'd0);
    check("b2b_count", 128'(xfer_t.size()), 128'd3);
    for (int i = 1; i < xfer_t.size(); i++)
      check("b2b_interval", 128'(xfer_t[i] - xfer_t[i-1]), 128'd5);

    // Reset asserted asynchronously while column 2 is being processed
    @(posedge clk); #1;
    issue(V_FIPS, E_FIPS, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out", out, 128'h0);
    @(posedge clk); #3;
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    check("midrst_no_stale_valid", 128'(saw), 128'd0);
    issue(V_ROW, E_ROW, 1'b1, 1'b0, 1'b0);
    wait_valid(n);
    check("latency_after_rst", 128'(n), 128'd4);
    @(posedge clk); #1;
    @(negedge clk);
    check("final_drained", 128'(exp_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
